// File: rtl/udp_panel_reader.sv
// Serves UDP pixel-read requests: reads panel words over the ctrl bus and returns them as a UDP reply.
// Define UDP_PANEL_READER_HEADER_EN to prefix each reply with a {start_addr, count} header word.
module udp_panel_reader #(
  parameter logic [7:0]  PORT_MSB   = 8'h66,
  parameter logic [15:0] MAX_PIXELS = 16'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        udp_source_valid,
  input  logic        udp_source_last,
  output logic        udp_source_ready,
  input  logic [15:0] udp_source_src_port,
  input  logic [15:0] udp_source_dst_port,
  input  logic [31:0] udp_source_ip_address,
  input  logic [15:0] udp_source_length,
  input  logic [31:0] udp_source_data,
  input  logic [3:0]  udp_source_error,
  output logic        udp_sink_valid,
  output logic        udp_sink_last,
  input  logic        udp_sink_ready,
  output logic [15:0] udp_sink_src_port,
  output logic [15:0] udp_sink_dst_port,
  output logic [31:0] udp_sink_ip_address,
  output logic [15:0] udp_sink_length,
  output logic [31:0] udp_sink_data,
  output logic [5:0]  ctrl_en,
  output logic [3:0]  ctrl_rd,
  output logic [15:0] ctrl_addr,
  input  logic [23:0] ctrl_rdat,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, REQ, READ, WAIT, SEND, FLUSH} state_t;

  state_t      state;
  logic [5:0]  panel;
  logic [31:0] reply_ip;
  logic [15:0] reply_dst, reply_src;
  logic [15:0] start_addr, count_eff, index, length;
  logic [7:0]  count_hi, sink_byte;
  logic [1:0]  req_cnt, byte_sel;
  logic [31:0] word;
  logic        hdr;

  logic        beat, launch, is_final;
  logic [15:0] cnt_raw, cnt_clamp, cnt_next;
  logic [7:0]  next_byte;
  logic        unused_bits;

  assign unused_bits = ^{udp_source_error, udp_source_data[31:8], udp_source_dst_port[7:6],
                         udp_source_length};

  assign beat                = udp_source_valid && udp_source_ready;
  assign ctrl_rd             = 4'b0111;
  assign busy                = (state != IDLE);
  assign udp_sink_data       = {24'd0, sink_byte};
  assign udp_sink_ip_address = reply_ip;
  assign udp_sink_dst_port   = reply_dst;
  assign udp_sink_src_port   = reply_src;
  assign udp_sink_length     = length;

  always_comb begin
    cnt_raw   = {count_hi, udp_source_data[7:0]};
    cnt_clamp = (cnt_raw > MAX_PIXELS) ? MAX_PIXELS : cnt_raw;
    cnt_next  = (state == REQ) ? cnt_clamp : count_eff;
    // The request is complete on the last beat, either inline with byte 3 or after a flush.
    launch    = beat && udp_source_last &&
                (((state == REQ) && (req_cnt == 2'd3)) || (state == FLUSH));
    is_final  = !hdr && ((index + 16'd1) == count_eff);
    case (byte_sel)
      2'd0:    next_byte = word[23:16];
      2'd1:    next_byte = word[15:8];
      default: next_byte = word[7:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      udp_source_ready <= 1'b0;
      udp_sink_valid   <= 1'b0;
      udp_sink_last    <= 1'b0;
      sink_byte        <= 8'd0;
      ctrl_en          <= 6'd0;
      ctrl_addr        <= 16'd0;
      index            <= 16'd0;
      hdr              <= 1'b0;
      req_cnt          <= 2'd0;
      byte_sel         <= 2'd0;
      length           <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          udp_source_ready <= 1'b1;
          index            <= 16'd0;
          if (beat && (udp_source_dst_port[15:8] == PORT_MSB)) begin
            panel            <= udp_source_dst_port[5:0];
            reply_ip         <= udp_source_ip_address;
            reply_dst        <= udp_source_src_port;
            reply_src        <= udp_source_dst_port;
            start_addr[15:8] <= udp_source_data[7:0];
            req_cnt          <= 2'd1;
            if (!udp_source_last) state <= REQ;
          end
        end
        REQ: if (beat) begin
          case (req_cnt)
            2'd1:    start_addr[7:0] <= udp_source_data[7:0];
            2'd2:    count_hi        <= udp_source_data[7:0];
            default: count_eff       <= cnt_clamp;
          endcase
          req_cnt <= req_cnt + 2'd1;
          if (req_cnt == 2'd3) begin
            if (!udp_source_last) state <= FLUSH;
          end else if (udp_source_last) begin
            state <= IDLE;
          end
        end
        FLUSH: ;
        READ: begin
          ctrl_en <= 6'd0;
          state   <= WAIT;
        end
        WAIT: begin
          word           <= {ctrl_addr[13:0], ctrl_rdat[21:16], ctrl_rdat[13:8], ctrl_rdat[5:0]};
          sink_byte      <= ctrl_addr[13:6];
          udp_sink_valid <= 1'b1;
          udp_sink_last  <= 1'b0;
          byte_sel       <= 2'd0;
          state          <= SEND;
        end
        SEND: if (udp_sink_valid && udp_sink_ready) begin
          if (byte_sel != 2'd3) begin
            byte_sel      <= byte_sel + 2'd1;
            sink_byte     <= next_byte;
            udp_sink_last <= (byte_sel == 2'd2) && is_final;
          end else begin
            udp_sink_valid <= 1'b0;
            udp_sink_last  <= 1'b0;
            if (hdr) begin
              hdr       <= 1'b0;
              ctrl_en   <= panel;
              ctrl_addr <= start_addr;
              state     <= READ;
            end else if (is_final) begin
              udp_source_ready <= 1'b1;
              state            <= IDLE;
            end else begin
              index     <= index + 16'd1;
              ctrl_en   <= panel;
              ctrl_addr <= start_addr + index + 16'd1;
              state     <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        if (cnt_next == 16'd0) begin
          state <= IDLE;
        end else begin
          udp_source_ready <= 1'b0;
          count_eff        <= cnt_next;
          index            <= 16'd0;
`ifdef UDP_PANEL_READER_HEADER_EN
          length         <= {cnt_next[13:0], 2'b00} + 16'd4;
          word           <= {start_addr, cnt_next};
          sink_byte      <= start_addr[15:8];
          udp_sink_valid <= 1'b1;
          udp_sink_last  <= 1'b0;
          byte_sel       <= 2'd0;
          hdr            <= 1'b1;
          state          <= SEND;
`else
          length    <= {cnt_next[13:0], 2'b00};
          ctrl_en   <= panel;
          ctrl_addr <= start_addr;
          state     <= READ;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_udp_panel_reader.sv
// Directed bench for udp_panel_reader (default build, no reply header).
module tb_udp_panel_reader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        udp_source_valid = 1'b0, udp_source_last = 1'b0, udp_source_ready;
  logic [15:0] udp_source_src_port = 16'h1234, udp_source_dst_port = 16'h0;
  logic [31:0] udp_source_ip_address = 32'hC0A80001;
  logic [15:0] udp_source_length = 16'd4;
  logic [31:0] udp_source_data = 32'd0;
  logic [3:0]  udp_source_error = 4'd0;
  logic        udp_sink_valid, udp_sink_last, udp_sink_ready = 1'b1;
  logic [15:0] udp_sink_src_port, udp_sink_dst_port, udp_sink_length;
  logic [31:0] udp_sink_ip_address, udp_sink_data;
  logic [5:0]  ctrl_en;
  logic [3:0]  ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_rdat = 24'h3F2A15;
  logic        busy;

  int n_err = 0, n_checks = 0;
  logic [7:0]  byte_q[$];
  logic        last_q[$];
  logic [15:0] len_q[$], addr_q[$];
  logic [5:0]  en_q[$];
  logic [23:0] hi_q[$];

  udp_panel_reader dut (
    .clock(clock), .reset(reset),
    .udp_source_valid(udp_source_valid), .udp_source_last(udp_source_last),
    .udp_source_ready(udp_source_ready), .udp_source_src_port(udp_source_src_port),
    .udp_source_dst_port(udp_source_dst_port), .udp_source_ip_address(udp_source_ip_address),
    .udp_source_length(udp_source_length), .udp_source_data(udp_source_data),
    .udp_source_error(udp_source_error),
    .udp_sink_valid(udp_sink_valid), .udp_sink_last(udp_sink_last),
    .udp_sink_ready(udp_sink_ready), .udp_sink_src_port(udp_sink_src_port),
    .udp_sink_dst_port(udp_sink_dst_port), .udp_sink_ip_address(udp_sink_ip_address),
    .udp_sink_length(udp_sink_length), .udp_sink_data(udp_sink_data),
    .ctrl_en(ctrl_en), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr), .ctrl_rdat(ctrl_rdat),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Inputs only change just after rising edges, so the falling edge sees what the next edge samples.
  always @(negedge clock) begin
    if (udp_sink_valid && udp_sink_ready) begin
      byte_q.push_back(udp_sink_data[7:0]);
      hi_q.push_back(udp_sink_data[31:8]);
      last_q.push_back(udp_sink_last);
      len_q.push_back(udp_sink_length);
    end
    if (ctrl_en != 6'd0) begin
      en_q.push_back(ctrl_en);
      addr_q.push_back(ctrl_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    byte_q.delete(); hi_q.delete(); last_q.delete(); len_q.delete();
    en_q.delete(); addr_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // bytes holds the payload MSB-first; the n-th byte carries last.
  task automatic send_req(input logic [15:0] dport, input logic [63:0] bytes, input int n);
    logic [63:0] b;
    bit ok;
    b = bytes;
    udp_source_dst_port = dport;
    for (int i = 0; i < n; i++) begin
      udp_source_valid = 1'b1;
      udp_source_data  = {24'd0, b[63-8*i -: 8]};
      udp_source_last  = (i == n - 1);
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clock);
        if (udp_source_ready) ok = 1;
      end
      @(posedge clock); #1;
      if (!ok) check("src_ready_timeout", 0, 1);
    end
    udp_source_valid = 1'b0;
    udp_source_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (!busy && !udp_sink_valid) ok = 1;
    end
    if (!ok) check(tag, 0, 1);
    tick(2);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {byte_q[i], byte_q[i+1], byte_q[i+2], byte_q[i+3]};
  endfunction

  int nl;
  logic [31:0] d0;
  bit ok;

  initial begin
    tick(3);
    check("rst_src_ready", udp_source_ready, 0);
    check("rst_sink_valid", udp_sink_valid, 0);
    check("rst_sink_last", udp_sink_last, 0);
    check("rst_sink_data", udp_sink_data, 0);
    check("rst_ctrl", {ctrl_en, ctrl_addr}, 0);
    check("rst_busy", busy, 0);
    check("ctrl_rd", ctrl_rd, 4'b0111);
    reset = 1'b0;
    tick(1);
    check("ready_after_rst", udp_source_ready, 1);

    // basic two-pixel read
    clear_q();
    send_req(16'h6603, 64'h00100002_00000000, 4);
    wait_done("t1_timeout");
    check("t1_reads", en_q.size(), 2);
    if (en_q.size() == 2) begin
      check("t1_en", {en_q[0], en_q[1]}, {6'h03, 6'h03});
      check("t1_addr", {addr_q[0], addr_q[1]}, 32'h0010_0011);
    end
    check("t1_bytes", byte_q.size(), 8);
    if (byte_q.size() == 8) begin
      check("t1_word0", word_at(0), 32'h0043FA95);
      check("t1_word1", word_at(4), 32'h0047FA95);
      nl = 0;
      foreach (last_q[i]) if (last_q[i]) nl++;
      check("t1_last", {nl, 31'd0, last_q[7]}, {32'd1, 31'd0, 1'b1});
      check("t1_len", {len_q[0], len_q[7]}, {16'd8, 16'd8});
      check("t1_hi_zero", hi_q[3], 0);
    end
    check("t1_ip", udp_sink_ip_address, 32'hC0A80001);
    check("t1_ports", {udp_sink_dst_port, udp_sink_src_port}, 32'h1234_6603);

    // sink back-pressure mid-packet
    clear_q();
    udp_sink_ready = 1'b0;
    send_req(16'h6605, 64'h00200001_00000000, 4);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clock);
      if (udp_sink_valid) ok = 1;
    end
    if (!ok) check("t2_valid_timeout", 0, 1);
    @(posedge clock); #1;
    udp_sink_ready = 1'b1;
    tick(1);
    udp_sink_ready = 1'b0;
    d0 = udp_sink_data;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check("t2_hold", {udp_sink_valid, udp_sink_data}, {1'b1, d0});
    end
    udp_sink_ready = 1'b1;
    wait_done("t2_timeout");
    check("t2_reads", en_q.size(), 1);
    if (en_q.size() == 1) check("t2_en", en_q[0], 6'h05);
    check("t2_bytes", byte_q.size(), 4);
    if (byte_q.size() == 4) check("t2_word", word_at(0), 32'h0083FA95);

    // count clamp
    clear_q();
    send_req(16'h6601, 64'h00000400_00000000, 4);
    wait_done("t3_timeout");
    check("t3_reads", en_q.size(), 256);
    check("t3_bytes", byte_q.size(), 1024);
    if (len_q.size() > 0) check("t3_len", len_q[0], 16'd1024);
    if (addr_q.size() == 256) check("t3_last_addr", addr_q[255], 16'h00FF);

    // address wrap
    clear_q();
    send_req(16'h6602, 64'hFFFF0002_00000000, 4);
    wait_done("t4_timeout");
    check("t4_reads", addr_q.size(), 2);
    if (addr_q.size() == 2) check("t4_addr", {addr_q[0], addr_q[1]}, 32'hFFFF_0000);
    if (byte_q.size() == 8) check("t4_word0", word_at(0), 32'hFFFFFA95);

    // wrong port, short request, zero count: no reply
    clear_q();
    send_req(16'h6501, 64'h00100002_00000000, 4);
    send_req(16'h6601, 64'h00050000_00000000, 2);
    send_req(16'h6601, 64'h00100000_00000000, 4);
    wait_done("t5_timeout");
    tick(10);
    check("t5_no_reply", {en_q.size(), byte_q.size()}, 0);
    check("t5_idle", busy, 0);

    // trailing bytes flushed, then served
    clear_q();
    send_req(16'h6604, 64'h00100001_AABB0000, 6);
    wait_done("t6_timeout");
    check("t6_reads", en_q.size(), 1);
    if (byte_q.size() == 4) check("t6_word", word_at(0), 32'h0043FA95);
    else check("t6_bytes", byte_q.size(), 4);

    // reset while presenting byte 2
    clear_q();
    udp_sink_ready = 1'b0;
    send_req(16'h6603, 64'h00100002_00000000, 4);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clock);
      if (udp_sink_valid) ok = 1;
    end
    if (!ok) check("t7_valid_timeout", 0, 1);
    @(posedge clock); #1;
    udp_sink_ready = 1'b1;
    tick(2);
    udp_sink_ready = 1'b0;
    check("t7_pre_bytes", byte_q.size(), 2);
    reset = 1'b1;
    tick(1);
    check("t7_rst", {udp_sink_valid, busy}, 0);
    reset = 1'b0;
    udp_sink_ready = 1'b1;
    tick(10);
    check("t7_no_more", byte_q.size(), 2);
    clear_q();
    send_req(16'h6603, 64'h00100001_00000000, 4);
    wait_done("t7_timeout");
    check("t7_bytes", byte_q.size(), 4);
    if (byte_q.size() == 4) check("t7_word", word_at(0), 32'h0043FA95);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
